// File: rtl/grf_multiport.sv
// Multi-port general register file with write-through bypass,
// per-entry pending scoreboard and a one-entry-per-cycle sweep clear.
module grf_multiport #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [WIDTH-1:0]        wdata0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [WIDTH-1:0]        wdata1,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rpend,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nx;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic wr0;
  logic wr1;
  logic iss;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign clr_busy = (state == SWEEP);

  // Qualified strobes: address 0 and the sweep window block everything
  assign wr0 = we0 && !clr_busy
            && !is_zero(waddr0);
  assign wr1 = we1 && !clr_busy
            && !is_zero(waddr1);
  assign iss = issue_en && !clr_busy
            && !is_zero(issue_addr);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = SWEEP;
          ptr_nx   = '0;
        end
      end
      SWEEP: begin
        ptr_nx = ptr + ADDR_W'(1);
        if (ptr == '1) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_busy) begin
      mem[ptr] <= '0;
    end else begin
      if (wr0) begin
        mem[waddr0] <= wdata0;
      end
      if (wr1) begin
        mem[waddr1] <= wdata1;
      end
    end
  end

  // Issue is applied after the write clears so it wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else if (clr_busy) begin
      pend[ptr] <= 1'b0;
    end else begin
      if (wr0) begin
        pend[waddr0] <= 1'b0;
      end
      if (wr1) begin
        pend[waddr1] <= 1'b0;
      end
      if (iss) begin
        pend[issue_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd;
    logic              rp;
    logic              wm;
    logic              im;

    assign ra = raddr[k*ADDR_W +: ADDR_W];
    assign wm = (wr0 && waddr0 == ra)
             || (wr1 && waddr1 == ra);
    assign im = iss && issue_addr == ra;

    always_comb begin
      rd = mem[ra];
      if (wr0 && waddr0 == ra) begin
        rd = wdata0;
      end
      if (wr1 && waddr1 == ra) begin
        rd = wdata1;
      end
      if (clr_busy || is_zero(ra)) begin
        rd = '0;
      end
    end

    always_comb begin
      rp = pend[ra];
      if (wm && !im) begin
        rp = 1'b0;
      end
      if (clr_busy || is_zero(ra)) begin
        rp = 1'b0;
      end
    end

    assign rdata[k*WIDTH +: WIDTH] = rd;
    assign rpend[k]                = rp;
  end

endmodule

// File: doc/grf_multiport.md
GRF_MULTIPORT -- requirements
Module: grf_multiport

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, the address width; depth is DEPTH = 2**ADDR_W.
REQ-003 The module SHALL have parameter NREAD, default 2, the number of read ports (1..4).
REQ-004 The module SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as 0 and ignores all writes and issues.
REQ-005 The module SHALL have one clock (clk) and an asynchronous, active-low reset (reset); the polarity and synchronicity are fixed.
REQ-006 The ports SHALL be:
  clk  in  1  clock, rising edge
  reset  in  1  asynchronous active-low reset
  we0 / waddr0 / wdata0  in  1 / ADDR_W / WIDTH  write port 0
  we1 / waddr1 / wdata1  in  1 / ADDR_W / WIDTH  write port 1
  raddr  in  NREAD*ADDR_W  read addresses, flattened; port k is at [k*ADDR_W +: ADDR_W]
  rdata  out  NREAD*WIDTH  read data, flattened in the same order
  rpend  out  NREAD  pending bit of each read address
  issue_en / issue_addr  in  1 / ADDR_W  marks an entry pending; it is a producer in flight
  clr_req  in  1  starts a sweep clear
  clr_busy  out  1  high while a sweep is in progress

Function
REQ-007 Writes SHALL commit on the rising clk edge when weN=1 and clr_busy=0.
REQ-008 When we0=we1=1 and waddr0==waddr1, port 1 SHALL win.
REQ-009 Reads SHALL be combinational, with write-through bypass per port:
  - if we1 matches, return wdata1;
  - else if we0 matches, return wdata0;
  - else return the array contents.
REQ-010 With ZERO_REG=1, any access to address 0 SHALL behave as follows: reads return 0, rpend returns 0, and no bypass applies.
REQ-011 The scoreboard SHALL hold one pending bit per entry:
  - issue_en sets pend[issue_addr];
  - a committed write to an address clears that address's pending bit.
REQ-012 When an issue and a write target the same address in the same cycle, pend SHALL end the cycle set, because the issue wins.
REQ-013 rpend[k] SHALL equal pend[raddr_k] with same-cycle bypass:
  - it reads 0 if a write to raddr_k is committing this cycle and no issue to raddr_k is present in the same cycle.
REQ-014 The sweep clear SHALL be a state machine with states IDLE and SWEEP and a sweep counter ptr of width ADDR_W.
REQ-015 In IDLE, clr_req=1 SHALL move the machine to SWEEP, set ptr=0 and raise clr_busy on the next cycle.
REQ-016 In SWEEP, each cycle SHALL zero entry[ptr] and pend[ptr] and increment ptr.
REQ-017 After ptr wraps from DEPTH-1, the machine SHALL return to IDLE; clr_busy stays high for exactly DEPTH cycles.
REQ-018 While clr_busy=1, the following SHALL hold:
  - writes and issues are dropped;
  - clr_req is ignored;
  - rdata and rpend read 0 for every port.
REQ-019 The ptr increment SHALL be modulo DEPTH with no overflow flag; all data paths SHALL be exactly WIDTH bits with no sign or zero extension.

Reset
REQ-020 An assertion of reset (reset=0) SHALL asynchronously force:
  - all entries to 0;
  - all pend bits to 0;
  - the state to IDLE, ptr to 0 and clr_busy to 0.
REQ-021 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block is IDLE and all entries read 0.
REQ-022 On release, the first rising edge with reset=1 SHALL accept writes and issues normally.

Verification
REQ-023 Write then read:
  - stimulus: we0=1, waddr0=5, wdata0=32'hDEADBEEF; in the same cycle raddr port0=5;
  - required: rdata0=32'hDEADBEEF by bypass in that cycle, and again from the array in the next cycle.
REQ-024 Dual write collision:
  - stimulus: we0=we1=1, both addresses 7, wdata0=32'h1, wdata1=32'h2;
  - required: the bypass read shows 32'h2, and entry 7 holds 32'h2 after the edge.
REQ-025 Zero register:
  - stimulus: we1=1, waddr1=0, wdata1=32'hFFFFFFFF; issue_en=1, issue_addr=0;
  - required: rdata for address 0 is 0 and rpend is 0, both in the same cycle and after the edge.
REQ-026 Scoreboard:
  - stimulus: issue addr 3; next cycle write addr 3 together with issue addr 3;
  - required: rpend(3)=1 after the first edge and still 1 after the second edge; a third-cycle write alone clears it.
REQ-027 Sweep:
  - setup: entries 1 and 31 are nonzero;
  - stimulus: pulse clr_req; during the sweep, attempt a write to 2;
  - required: clr_busy is high for 32 cycles, the write is dropped, and all reads return 0 afterwards.
REQ-028 Reset mid-sweep:
  - stimulus: assert reset at sweep cycle 10 without a clock edge;
  - required: clr_busy=0 immediately, all entries read 0, and after release a write to 4 with 32'hA5A5A5A5 succeeds.
